// File: rtl/clock_pkg.sv
// Shared constants, set-command encodings and alarm state type for the time-of-day core.
// Optional build macro HOUR12_EN selects 12-hour display format (see hour_to_12).
package clock_pkg;

    localparam logic [6:0] SEC_MAX    = 7'd59;
    localparam logic [6:0] MIN_MAX    = 7'd59;
    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] BLANK_CODE = 7'd60;

    typedef enum logic [1:0] {
        SEL_TIME  = 2'd0,
        SEL_ALARM = 2'd1,
        SEL_ALOFF = 2'd2,
        SEL_RSVD  = 2'd3
    } set_sel_t;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_RING = 1'b1
    } alarm_state_t;

    // Internal hours are always 0..23; this maps them to the 1..12 display form.
    function automatic logic [6:0] hour_to_12(input logic [6:0] h);
        if (h == 7'd0)
            return 7'd12;
        else if (h > 7'd12)
            return h - 7'd12;
        else
            return h;
    endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ clocks; clr restarts the count so the
// next tick lands a full CLK_HZ cycles later.
module clk_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_q <= '0;
        else if (clr || div_q == DIV_LAST)
            div_q <= '0;
        else
            div_q <= div_q + 1'b1;
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/clock_timebase.sv
// Time-of-day core: 1 Hz carry chain 59/59/23, time/alarm loads, and an alarm that
// blanks the seconds display while ringing. Build macro HOUR12_EN adds 12-hour output and pm_o.
module clock_timebase
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [1:0] set_sel,
    input  logic [6:0] set_h,
    input  logic [6:0] set_m,
    input  logic [6:0] set_s,
    output logic       set_err,
    input  logic       alarm_ack,
    output logic       tick_1hz,
    output logic       alarm_o,
    output logic [6:0] L,
    output logic [6:0] M,
`ifdef HOUR12_EN
    output logic       pm_o,
`endif
    output logic [6:0] B
);

    localparam logic [5:0] RING_INIT = 6'(ALARM_SECS);

    // Handshake: a load transfers on any rising clk where set_valid && set_ready.
    // set_ready is always 1, so set_valid alone is the request; a transfer whose
    // fields are out of range (or sel is reserved) changes nothing and pulses set_err.
    set_sel_t     sel;
    logic         xfer, fields_ok, accept;
    logic         load_time, load_alarm, alarm_off;
    logic         tick, tick_adv, alarm_hit;
    logic [6:0]   sec_q, min_q, hour_q;
    logic [6:0]   sec_inc, min_inc, hour_inc;
    logic         sec_wrap, min_wrap;
    logic [6:0]   alarm_h_q, alarm_m_q;
    logic         alarm_en_q, set_err_q;
    alarm_state_t state_q, state_d;
    logic [5:0]   ring_cnt_q, ring_cnt_d;

    assign set_ready = 1'b1;
    assign sel       = set_sel_t'(set_sel);
    assign xfer      = set_valid && set_ready;

    always_comb begin
        fields_ok = 1'b0;
        case (sel)
            SEL_TIME:  fields_ok = (set_h <= HOUR_MAX) && (set_m <= MIN_MAX) && (set_s <= SEC_MAX);
            SEL_ALARM: fields_ok = (set_h <= HOUR_MAX) && (set_m <= MIN_MAX);
            SEL_ALOFF: fields_ok = 1'b1;
            default:   fields_ok = 1'b0;
        endcase
    end

    assign accept     = xfer && fields_ok;
    assign load_time  = accept && (sel == SEL_TIME);
    assign load_alarm = accept && (sel == SEL_ALARM);
    assign alarm_off  = accept && (sel == SEL_ALOFF);

    clk_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_time),
        .tick  (tick)
    );

    assign tick_1hz = tick;
    // A time load in the tick cycle wins; the increment is dropped.
    assign tick_adv = tick && !load_time;

    always_comb begin
        sec_wrap = (sec_q == SEC_MAX);
        min_wrap = (min_q == MIN_MAX);
        sec_inc  = sec_wrap ? 7'd0 : sec_q + 7'd1;
        min_inc  = min_q;
        hour_inc = hour_q;
        if (sec_wrap)
            min_inc = min_wrap ? 7'd0 : min_q + 7'd1;
        if (sec_wrap && min_wrap)
            hour_inc = (hour_q == HOUR_MAX) ? 7'd0 : hour_q + 7'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else if (load_time) begin
            sec_q  <= set_s;
            min_q  <= set_m;
            hour_q <= set_h;
        end else if (tick) begin
            sec_q  <= sec_inc;
            min_q  <= min_inc;
            hour_q <= hour_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_h_q  <= '0;
            alarm_m_q  <= '0;
            alarm_en_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            set_err_q <= xfer && !fields_ok;
            if (load_alarm) begin
                alarm_h_q  <= set_h;
                alarm_m_q  <= set_m;
                alarm_en_q <= 1'b1;
            end else if (alarm_off) begin
                alarm_en_q <= 1'b0;
            end
        end
    end

    // Only a tick increment onto hh:mm:00 fires the alarm; a load onto it does not.
    assign alarm_hit = alarm_en_q && tick_adv && sec_wrap &&
                       (min_inc == alarm_m_q) && (hour_inc == alarm_h_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= A_IDLE;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            A_IDLE: begin
                if (alarm_hit) begin
                    state_d    = A_RING;
                    ring_cnt_d = RING_INIT;
                end
            end
            A_RING: begin
                if (alarm_ack || load_time || alarm_off) begin
                    state_d    = A_IDLE;
                    ring_cnt_d = '0;
                end else if (tick) begin
                    ring_cnt_d = ring_cnt_q - 6'd1;
                    if (ring_cnt_q <= 6'd1)
                        state_d = A_IDLE;
                end
            end
            default: begin
                state_d    = A_IDLE;
                ring_cnt_d = '0;
            end
        endcase
    end

    assign alarm_o = (state_q == A_RING);
    assign set_err = set_err_q;
    assign L       = alarm_o ? BLANK_CODE : sec_q;
    assign M       = min_q;

`ifdef HOUR12_EN
    assign B    = hour_to_12(hour_q);
    assign pm_o = (hour_q >= 7'd12);
`else
    assign B    = hour_q;
`endif

endmodule

// File: tb/tb_clock_timebase.sv
// Directed bench for clock_timebase at CLK_HZ=10, ALARM_SECS=30; immediate assertions
// at every comparison, one summary line at the end.
module tb_clock_timebase;

    localparam int CLK_HZ     = 10;
    localparam int ALARM_SECS = 30;

    logic       clk;
    logic       rst_n;
    logic       set_valid;
    logic       set_ready;
    logic [1:0] set_sel;
    logic [6:0] set_h, set_m, set_s;
    logic       set_err;
    logic       alarm_ack;
    logic       tick_1hz;
    logic       alarm_o;
    logic [6:0] L, M, B;
`ifdef HOUR12_EN
    logic       pm_o;
`endif

    int total = 0;
    int bad   = 0;

    clock_timebase #(
        .CLK_HZ     (CLK_HZ),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_sel   (set_sel),
        .set_h     (set_h),
        .set_m     (set_m),
        .set_s     (set_s),
        .set_err   (set_err),
        .alarm_ack (alarm_ack),
        .tick_1hz  (tick_1hz),
        .alarm_o   (alarm_o),
        .L         (L),
        .M         (M),
`ifdef HOUR12_EN
        .pm_o      (pm_o),
`endif
        .B         (B)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [6:0] h, input logic [6:0] m,
                        input logic [6:0] s);
        set_valid = 1'b1;
        set_sel   = sel;
        set_h     = h;
        set_m     = m;
        set_s     = s;
        step(1);
        set_valid = 1'b0;
    endtask

    task automatic wait_tick(input string tag, output int n);
        n = 0;
        while (!tick_1hz && n < 30) begin
            step(1);
            n++;
        end
        check(tag, {31'd0, tick_1hz}, 32'd1);
    endtask

    task automatic next_sec(input string tag);
        int n;
        wait_tick(tag, n);
        step(1);
    endtask

    initial begin
        int n;
        int last_tick;
        int ticks;

        rst_n     = 1'b0;
        set_valid = 1'b0;
        set_sel   = 2'd0;
        set_h     = '0;
        set_m     = '0;
        set_s     = '0;
        alarm_ack = 1'b0;

        step(3);
        check("rst_L", L, 0);
        check("rst_M", M, 0);
        check("rst_B", B, 0);
        check("rst_tick", tick_1hz, 0);
        check("rst_alarm", alarm_o, 0);
        check("rst_err", set_err, 0);
        check("rst_ready", set_ready, 1);
        rst_n = 1'b1;

        // free run 600 cycles: 60 ticks, one every 10 cycles
        last_tick = -1;
        ticks     = 0;
        for (int c = 1; c <= 600; c++) begin
            step(1);
            if (tick_1hz) begin
                if (last_tick < 0)
                    check("first_tick_cycle", c, 9);
                else
                    check("tick_spacing", c - last_tick, 10);
                check("run_L", L, ticks % 60);
                last_tick = c;
                ticks++;
            end
        end
        check("tick_count", ticks, 60);
        check("run_end_L", L, 0);
        check("run_end_M", M, 1);
        check("run_end_B", B, 0);

        // day rollover
        load(2'd0, 7'd23, 7'd59, 7'd58);
        check("ld_err", set_err, 0);
        check("ld_L", L, 58);
        check("ld_M", M, 59);
        check("ld_B", B, 23);
        wait_tick("ld_tick", n);
        check("ld_tick_delay", n, 9);
        step(1);
        check("roll59_L", L, 59);
        next_sec("roll_tick");
        check("roll_L", L, 0);
        check("roll_M", M, 0);
        check("roll_B", B, 0);
        next_sec("roll1_tick");
        check("roll1_L", L, 1);

        // rejected loads
        load(2'd0, 7'd24, 7'd0, 7'd0);
        check("bad_h_err", set_err, 1);
        check("bad_h_L", L, 1);
        check("bad_h_M", M, 0);
        check("bad_h_B", B, 0);
        step(1);
        check("err_pulse", set_err, 0);
        load(2'd3, 7'd1, 7'd1, 7'd1);
        check("sel3_err", set_err, 1);
        step(1);
        load(2'd1, 7'd0, 7'd60, 7'd0);
        check("bad_am_err", set_err, 1);
        check("bad_am_L", L, 1);

        // alarm rings for ALARM_SECS ticks
        load(2'd1, 7'd0, 7'd1, 7'd99);
        check("al_ld_err", set_err, 0);
        load(2'd0, 7'd0, 7'd0, 7'd59);
        check("al_pre", alarm_o, 0);
        next_sec("al_tick");
        check("ring_on", alarm_o, 1);
        check("ring_L", L, 60);
        check("ring_M", M, 1);
        check("ring_B", B, 0);
        for (int k = 1; k < ALARM_SECS; k++) next_sec("ring_tick");
        check("ring_hold", alarm_o, 1);
        check("ring_hold_L", L, 60);
        next_sec("ring_last");
        check("ring_off", alarm_o, 0);
        check("ring_off_L", L, 30);
        check("ring_off_M", M, 1);

        // ack coincident with a tick
        load(2'd0, 7'd0, 7'd1, 7'd59);
        load(2'd1, 7'd0, 7'd2, 7'd0);
        next_sec("ack_arm");
        check("ack_ring", alarm_o, 1);
        check("ack_ring_M", M, 2);
        wait_tick("ack_tick", n);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        check("ack_off", alarm_o, 0);
        check("ack_L", L, 1);
        check("ack_M", M, 2);

        // disabled alarm does not ring
        load(2'd1, 7'd0, 7'd3, 7'd0);
        load(2'd2, 7'd0, 7'd0, 7'd0);
        check("aloff_err", set_err, 0);
        load(2'd0, 7'd0, 7'd2, 7'd59);
        next_sec("aloff_tick");
        check("aloff_quiet", alarm_o, 0);
        check("aloff_L", L, 0);
        check("aloff_M", M, 3);

        // time load coincident with tick
        wait_tick("co_tick", n);
        load(2'd0, 7'd10, 7'd20, 7'd30);
        check("co_L", L, 30);
        check("co_M", M, 20);
        check("co_B", B, 10);
        wait_tick("co_next", n);
        check("co_delay", n, 9);
        step(1);
        check("co_inc_L", L, 31);

        // asynchronous reset mid-ring
        load(2'd1, 7'd10, 7'd21, 7'd0);
        load(2'd0, 7'd10, 7'd20, 7'd59);
        next_sec("rr_tick");
        check("rr_ring", alarm_o, 1);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_L", L, 0);
        check("ar_M", M, 0);
        check("ar_B", B, 0);
        check("ar_alarm", alarm_o, 0);
        check("ar_tick", tick_1hz, 0);
        check("ar_err", set_err, 0);
        check("ar_ready", set_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(2);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
